// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
package imem_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic            err;
  } fetch_entry_t;

  // Misaligned, or beyond the last stored word (addr >= depth*4).
  function automatic logic is_fetch_err(input logic [XLEN-1:0] addr,
                                        input int unsigned     depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[XLEN-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch request / response handshake bundle between the PC stage (master)
// and the instruction-memory responder (slave).
interface imem_fetch_responder_if;
  import imem_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic [XLEN-1:0] rsp_addr;
  logic            rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

endinterface

// File: rtl/imem_rsp_fifo.sv
// Show-ahead synchronous FIFO of fetch entries with a clear input.
// A write in the clear cycle survives and becomes the only entry.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         wr_en_i,
  input  fetch_entry_t wr_data_i,
  input  logic         rd_en_i,
  output fetch_entry_t rd_data_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic [AW-1:0] wr_idx_w;

  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign wr_idx_w = clr_i ? '0 : wr_ptr_q[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= {{AW{1'b0}}, wr_en_i};
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i)             wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en_i && !empty_o) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i && !rst) mem_q[wr_idx_w] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory read responder: in-order fetch responses after LATENCY cycles,
// credit-based req_ready. Optional flush port when IMEM_FLUSH_EN is defined.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    LATENCY     = 2,
  parameter int    FIFO_DEPTH  = 4,
  parameter string INIT_FILE   = ""
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef IMEM_FLUSH_EN
  input  logic                   flush_i,
`endif
  imem_fetch_responder_if.slave  bus,
  output logic                   busy_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0]  mem_q [DEPTH_WORDS];
  logic [CW-1:0]    credits_q;
  logic             acc_w, pop_w, flush_w, wr_en_w, fifo_empty_w;
  logic [IDX_W-1:0] idx_w;
  fetch_entry_t     req_ent_w, wr_ent_w, fifo_in_w, fifo_out_w;

  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] = '0;
  end

`ifdef IMEM_FLUSH_EN
  assign flush_w = flush_i;
`else
  assign flush_w = 1'b0;
`endif

  assign bus.req_ready = !rst && (credits_q < CW'(FIFO_DEPTH));
  assign acc_w         = bus.req_valid && bus.req_ready;
  assign pop_w         = bus.rsp_valid && bus.rsp_ready;
  assign idx_w         = bus.req_addr[IDX_W+1:2];

  always_comb begin
    req_ent_w.addr = bus.req_addr;
    req_ent_w.err  = is_fetch_err(bus.req_addr, DEPTH_WORDS);
    req_ent_w.data = mem_q[idx_w];
  end

  // The final stage writes the FIFO, so LATENCY-1 registers precede it.
  if (LATENCY == 1) begin : g_lat1
    assign wr_en_w  = acc_w;
    assign wr_ent_w = req_ent_w;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld_q;
    fetch_entry_t       ent_q [LATENCY-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= acc_w;
        for (int s = 1; s < LATENCY - 1; s++) vld_q[s] <= vld_q[s-1] && !flush_w;
      end
    end

    always_ff @(posedge clk) begin
      ent_q[0] <= req_ent_w;
      for (int s = 1; s < LATENCY - 1; s++) ent_q[s] <= ent_q[s-1];
    end

    assign wr_en_w  = vld_q[LATENCY-2] && !flush_w;
    assign wr_ent_w = ent_q[LATENCY-2];
  end

  // NOP substitution sits after the array read so the read stage stays a plain RAM port.
  always_comb begin
    fifo_in_w = wr_ent_w;
    if (wr_ent_w.err) fifo_in_w.data = NOP_INSTR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q <= '0;
    end else if (flush_w) begin
      credits_q <= acc_w ? CW'(1) : '0;
    end else if (acc_w && !pop_w) begin
      credits_q <= credits_q + CW'(1);
    end else if (!acc_w && pop_w) begin
      credits_q <= credits_q - CW'(1);
    end
  end

  imem_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (flush_w),
    .wr_en_i   (wr_en_w),
    .wr_data_i (fifo_in_w),
    .rd_en_i   (pop_w),
    .rd_data_o (fifo_out_w),
    .empty_o   (fifo_empty_w)
  );

  assign bus.rsp_valid = !fifo_empty_w;
  assign bus.rsp_data  = fifo_out_w.data;
  assign bus.rsp_addr  = fifo_out_w.addr;
  assign bus.rsp_err   = fifo_out_w.err;
  assign busy_o        = (credits_q != '0);

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Randomized self-checking bench for imem_fetch_responder against a queue-based
// reference model (due-cycle per accepted fetch). Flush tests need IMEM_FLUSH_EN.
module tb_imem_fetch_responder;
  import imem_pkg::*;

  localparam int DEPTH_WORDS = 1024;
  localparam int LATENCY     = 2;
  localparam int FIFO_DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
`ifdef IMEM_FLUSH_EN
  logic flush = 1'b0;
`endif

  imem_fetch_responder_if bus ();

  imem_fetch_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LATENCY     (LATENCY),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .INIT_FILE   ("")
  ) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef IMEM_FLUSH_EN
    .flush_i (flush),
`endif
    .bus     (bus),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic [31:0] img [DEPTH_WORDS];
  exp_t        pend [$];
  int          credits = 0;
  int          cyc     = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic exp_t model_entry(input logic [31:0] a, input int due);
    exp_t e;
    e.addr = a;
    e.err  = (a % 4 != 0) || (a >= 32'(DEPTH_WORDS * 4));
    e.data = e.err ? 32'h0000_0013 : img[a / 4];
    e.due  = due;
    return e;
  endfunction

  // Called right after a falling edge; returns at the next falling edge.
  task automatic step(input logic v, input logic [31:0] a, input logic rr,
                      input logic fl, output logic got_acc);
    logic exp_rdy, exp_vld, acc, pop;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.rsp_ready = rr;
`ifdef IMEM_FLUSH_EN
    flush = fl;
`endif
    #1;
    exp_rdy = (credits < FIFO_DEPTH);
    exp_vld = (pend.size() > 0) && (pend[0].due <= cyc);
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("rsp_valid", bus.rsp_valid, exp_vld);
    chk("busy",      busy, credits != 0);
    if (exp_vld) begin
      chk("rsp_data", bus.rsp_data, pend[0].data);
      chk("rsp_addr", bus.rsp_addr, pend[0].addr);
      chk("rsp_err",  bus.rsp_err,  pend[0].err);
    end
    got_acc = v && bus.req_ready;
    acc     = v && exp_rdy;
    pop     = exp_vld && rr;
    @(posedge clk);
    cyc++;
    if (fl) begin
      pend.delete();
      credits = 0;
    end else if (pop) begin
      void'(pend.pop_front());
      credits--;
    end
    if (acc) begin
      pend.push_back(model_entry(a, cyc + LATENCY - 1));
      credits++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int ncyc);
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
`ifdef IMEM_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data",  bus.rsp_data,  0);
    chk("rst_rsp_addr",  bus.rsp_addr,  0);
    chk("rst_rsp_err",   bus.rsp_err,   0);
    chk("rst_busy",      busy,          0);
    rst = 1'b0;
    pend.delete();
    credits = 0;
    cyc     = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ga;
    logic [31:0] pc;
    int          n_acc;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH_WORDS; i++) img[i] = $urandom;
    img[0] = 32'h0050_0093;
    #1;
    for (int i = 0; i < DEPTH_WORDS; i++) dut.mem_q[i] = img[i];
    do_reset(3);

    // single fetch at 0x0
    step(1'b1, 32'h0, 1'b1, 1'b0, ga);
    repeat (4) step(1'b0, $urandom, 1'b1, 1'b0, ga);

    // back-to-back 0x0..0x1C
    for (int i = 0; i < 8; i++) step(1'b1, 32'(i * 4), 1'b1, 1'b0, ga);
    repeat (LATENCY + 2) step(1'b0, 32'h0, 1'b1, 1'b0, ga);

    // consumer stalled: exactly FIFO_DEPTH accepts, then release
    pc    = 32'h100;
    n_acc = 0;
    repeat (8) begin
      step(1'b1, pc, 1'b0, 1'b0, ga);
      if (ga) begin n_acc++; pc += 4; end
    end
    chk("stall_accepts", 32'(n_acc), 32'(FIFO_DEPTH));
    repeat (8) begin
      step(1'b1, pc, 1'b1, 1'b0, ga);
      if (ga) pc += 4;
    end
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0, ga);

    // error fetches
    step(1'b1, 32'h0000_0002, 1'b1, 1'b0, ga);
    step(1'b1, 32'h0000_1000, 1'b1, 1'b0, ga);
    step(1'b1, 32'h0000_0FFC, 1'b1, 1'b0, ga);
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, ga);
    repeat (LATENCY + 3) step(1'b0, 32'h0, 1'b1, 1'b0, ga);

    // reset with three fetches in flight
    for (int i = 0; i < 3; i++) step(1'b1, 32'(32'h10 + i * 4), 1'b0, 1'b0, ga);
    do_reset(2);
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b0, ga);
    step(1'b1, 32'h0, 1'b1, 1'b0, ga);
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0, ga);

`ifdef IMEM_FLUSH_EN
    // flush with three in flight and a simultaneous redirect fetch
    for (int i = 0; i < 3; i++) step(1'b1, 32'(32'h20 + i * 4), 1'b0, 1'b0, ga);
    step(1'b1, 32'h40, 1'b1, 1'b1, ga);
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b0, ga);
`endif

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a;
      int          kind;
      logic        fl;
      kind = int'($urandom_range(0, 7));
      if (kind == 0)      a = 32'($urandom_range(0, 1023) * 4) | 32'($urandom_range(1, 3));
      else if (kind == 1) a = 32'h1000 + 32'($urandom_range(0, 4095) * 4);
      else                a = 32'($urandom_range(0, 1023) * 4);
      fl = 1'b0;
`ifdef IMEM_FLUSH_EN
      fl = ($urandom_range(0, 63) == 0);
`endif
      step($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0, fl, ga);
    end
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b0, ga);
    chk("final_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
